// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: picks the deepest active hold vector, redirects the PC on
// MEM-stage exceptions and sequences the multi-cycle divider sitting in EX.
module hazard_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_raddr1_i,
    input  logic [4:0]  id_raddr2_i,
    input  logic        id_re1_i,
    input  logic        id_re2_i,
    input  logic        ex_is_load_i,
    input  logic        ex_we_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic        ex_div_req_i,
    input  logic        div_done_i,
    input  logic        ibus_stall_i,
    input  logic        dbus_stall_i,
    input  logic        mem_excp_i,
    input  logic [31:0] mem_excp_pc_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        div_start_o,
    output logic        div_cancel_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

    localparam logic [5:0] StallDbus    = 6'b011111;
    localparam logic [5:0] StallDiv     = 6'b001111;
    localparam logic [5:0] StallLoadUse = 6'b000111;
    localparam logic [5:0] StallIbus    = 6'b000011;

    div_state_e state_q;

    logic       load_use;
    logic       div_stall;
    logic [5:0] stall_vec;

    always_comb begin
        load_use = ex_is_load_i && ex_we_i && (ex_waddr_i != 5'd0) &&
                   ((id_re1_i && (id_raddr1_i == ex_waddr_i)) ||
                    (id_re2_i && (id_raddr2_i == ex_waddr_i)));

        // DONE releases EX; IDLE only holds when it is launching a new divide.
        div_stall = (state_q == StBusy) ||
                    ((state_q == StIdle) && ex_div_req_i && !mem_excp_i);

        if (dbus_stall_i) begin
            stall_vec = StallDbus;
        end else if (div_stall) begin
            stall_vec = StallDiv;
        end else if (load_use) begin
            stall_vec = StallLoadUse;
        end else if (ibus_stall_i) begin
            stall_vec = StallIbus;
        end else begin
            stall_vec = 6'b000000;
        end
    end

    always_comb begin
        stall_o      = 6'b000000;
        flush_o      = 1'b0;
        new_pc_o     = 32'h0;
        div_start_o  = 1'b0;
        div_cancel_o = 1'b0;
        if (!rst_i) begin
            if (mem_excp_i) begin
                flush_o      = 1'b1;
                new_pc_o     = mem_excp_pc_i;
                div_cancel_o = (state_q == StBusy);
            end else begin
                stall_o     = stall_vec;
                div_start_o = (state_q == StIdle) && ex_div_req_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || mem_excp_i) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (ex_div_req_i) state_q <= StBusy;
                StBusy: if (div_done_i) state_q <= StDone;
                // The divided instruction leaves EX only once EX is no longer held.
                StDone: if (!stall_o[3]) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic compared
// against a cycle-level reference model of the stall/flush rules.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  raddr1 = '0, raddr2 = '0, waddr = '0;
    logic        re1 = 1'b0, re2 = 1'b0, is_load = 1'b0, we = 1'b0;
    logic        req = 1'b0, done = 1'b0, ibus = 1'b0, dbus = 1'b0, excp = 1'b0;
    logic [31:0] excp_pc = '0;

    logic [5:0]  stall_o;
    logic        flush_o, div_start_o, div_cancel_o;
    logic [31:0] new_pc_o;
    logic [40:0] act, want;

    int n_vec = 0;
    int n_err = 0;

    // Model: a divide waiting for its result, and a finished divide still sitting in EX.
    bit div_pending = 1'b0;
    bit div_result_held = 1'b0;

    always #5 clk = ~clk;

    assign act = {stall_o, flush_o, new_pc_o, div_start_o, div_cancel_o};

    hazard_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_raddr1_i   (raddr1),
        .id_raddr2_i   (raddr2),
        .id_re1_i      (re1),
        .id_re2_i      (re2),
        .ex_is_load_i  (is_load),
        .ex_we_i       (we),
        .ex_waddr_i    (waddr),
        .ex_div_req_i  (req),
        .div_done_i    (done),
        .ibus_stall_i  (ibus),
        .dbus_stall_i  (dbus),
        .mem_excp_i    (excp),
        .mem_excp_pc_i (excp_pc),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .new_pc_o      (new_pc_o),
        .div_start_o   (div_start_o),
        .div_cancel_o  (div_cancel_o)
    );

    function automatic logic [40:0] model_out();
        int         depth;
        bit         hazard, new_div;
        logic [5:0] st;
        if (rst) return '0;
        if (excp) return {6'b0, 1'b1, excp_pc, 1'b0, div_pending};
        hazard  = is_load && we && waddr != 0 &&
                  ((re1 && raddr1 == waddr) || (re2 && raddr2 == waddr));
        new_div = !div_pending && !div_result_held && req;
        depth = 0;
        if (ibus) depth = 2;
        if (hazard) depth = 3;
        if (div_pending || new_div) depth = 4;
        if (dbus) depth = 5;
        st = 6'((1 << depth) - 1);
        return {st, 1'b0, 32'h0, new_div, 1'b0};
    endfunction

    task automatic model_step();
        logic [40:0] o;
        o = model_out();
        if (rst || excp) begin
            div_pending     = 1'b0;
            div_result_held = 1'b0;
        end else if (div_pending) begin
            if (done) begin
                div_pending     = 1'b0;
                div_result_held = 1'b1;
            end
        end else if (div_result_held) begin
            if (!o[38]) div_result_held = 1'b0;
        end else if (req) begin
            div_pending = 1'b1;
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        {raddr1, raddr2, waddr} = '0;
        {re1, re2, is_load, we, req, done, ibus, dbus, excp} = '0;
        excp_pc = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            rst = 1'b1;
            {req, done, ibus, dbus, excp} = 5'($urandom);
            excp_pc = $urandom;
            #1;
            n_vec++;
            if (act !== 41'h0) begin
                n_err++;
                $display("FAIL reset_outputs: got %h want %h", act, 41'h0);
            end
            tick();
        end
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        is_load = 1; we = 1; waddr = 5; re2 = 1; raddr2 = 5; re1 = 1; raddr1 = 7;
        want = {6'b000111, 1'b0, 32'h0, 2'b00};
        #1; n_vec++;
        if (act !== want) begin
            n_err++; $display("FAIL load_use_port2: got %h want %h", act, want);
        end
        tick();
        is_load = 0; we = 0; waddr = 0;
        want = '0;
        #1; n_vec++;
        if (act !== want) begin
            n_err++; $display("FAIL load_use_bubble: got %h want %h", act, want);
        end
        tick();
        is_load = 1; we = 1; waddr = 0; re2 = 1; raddr2 = 0; re1 = 1; raddr1 = 0;
        #1; n_vec++;
        if (act !== want) begin
            n_err++; $display("FAIL load_use_r0: got %h want %h", act, want);
        end
        tick();
        waddr = 9; raddr1 = 9; re1 = 1; re2 = 0; raddr2 = 9;
        want = {6'b000111, 1'b0, 32'h0, 2'b00};
        #1; n_vec++;
        if (act !== want) begin
            n_err++; $display("FAIL load_use_port1: got %h want %h", act, want);
        end
        tick();
        re1 = 0;
        want = '0;
        #1; n_vec++;
        if (act !== want) begin
            n_err++; $display("FAIL load_use_no_re: got %h want %h", act, want);
        end
        tick();
    endtask

    task automatic test_divide();
        do_reset();
        req = 1;
        want = {6'b001111, 1'b0, 32'h0, 2'b10};
        #1; n_vec++;
        if (act !== want) begin
            n_err++; $display("FAIL div_start: got %h want %h", act, want);
        end
        tick();
        want = {6'b001111, 1'b0, 32'h0, 2'b00};
        for (int i = 1; i <= 32; i++) begin
            done = (i == 32);
            #1; n_vec++;
            if (act !== want) begin
                n_err++; $display("FAIL div_busy_%0d: got %h want %h", i, act, want);
            end
            tick();
        end
        done = 0;
        want = '0;
        #1; n_vec++;
        if (act !== want) begin
            n_err++; $display("FAIL div_done_cycle: got %h want %h", act, want);
        end
        tick();
        req = 0;
        #1; n_vec++;
        if (act !== want) begin
            n_err++; $display("FAIL div_after_done: got %h want %h", act, want);
        end
        tick();
        req = 1;
        want = {6'b001111, 1'b0, 32'h0, 2'b10};
        #1; n_vec++;
        if (act !== want) begin
            n_err++; $display("FAIL div_idle_restart: got %h want %h", act, want);
        end
        tick();
    endtask

    task automatic test_div_dbus();
        do_reset();
        req = 1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        done = 1; dbus = 1;
        want = {6'b011111, 1'b0, 32'h0, 2'b00};
        #1; n_vec++;
        if (act !== want) begin
            n_err++; $display("FAIL div_done_dbus: got %h want %h", act, want);
        end
        tick();
        done = 0;
        for (int i = 0; i < 3; i++) begin
            #1; n_vec++;
            if (act !== want) begin
                n_err++; $display("FAIL div_hold_dbus_%0d: got %h want %h", i, act, want);
            end
            tick();
        end
        dbus = 0;
        want = '0;
        #1; n_vec++;
        if (act !== want) begin
            n_err++; $display("FAIL div_dbus_release: got %h want %h", act, want);
        end
        tick();
        want = {6'b001111, 1'b0, 32'h0, 2'b10};
        #1; n_vec++;
        if (act !== want) begin
            n_err++; $display("FAIL div_dbus_next_start: got %h want %h", act, want);
        end
        tick();
    endtask

    task automatic test_excp_mid_div();
        do_reset();
        req = 1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        excp = 1; excp_pc = 32'hBFC00380; dbus = 1; ibus = 1;
        want = {6'b000000, 1'b1, 32'hBFC00380, 2'b01};
        #1; n_vec++;
        if (act !== want) begin
            n_err++; $display("FAIL excp_cancel: got %h want %h", act, want);
        end
        tick();
        excp = 0; excp_pc = 0; dbus = 0; ibus = 0;
        want = {6'b001111, 1'b0, 32'h0, 2'b10};
        #1; n_vec++;
        if (act !== want) begin
            n_err++; $display("FAIL excp_then_idle: got %h want %h", act, want);
        end
        tick();
    endtask

    task automatic test_priority();
        do_reset();
        ibus = 1;
        want = {6'b000011, 1'b0, 32'h0, 2'b00};
        #1; n_vec++;
        if (act !== want) begin
            n_err++; $display("FAIL prio_ibus: got %h want %h", act, want);
        end
        is_load = 1; we = 1; waddr = 3; re1 = 1; raddr1 = 3;
        want = {6'b000111, 1'b0, 32'h0, 2'b00};
        #1; n_vec++;
        if (act !== want) begin
            n_err++; $display("FAIL prio_lu_ibus: got %h want %h", act, want);
        end
        dbus = 1;
        want = {6'b011111, 1'b0, 32'h0, 2'b00};
        #1; n_vec++;
        if (act !== want) begin
            n_err++; $display("FAIL prio_dbus: got %h want %h", act, want);
        end
        dbus = 0; req = 1;
        want = {6'b001111, 1'b0, 32'h0, 2'b10};
        #1; n_vec++;
        if (act !== want) begin
            n_err++; $display("FAIL prio_div_lu: got %h want %h", act, want);
        end
        tick();
    endtask

    task automatic test_reset_mid_div();
        do_reset();
        req = 1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        rst = 1; done = 1; ibus = 1; dbus = 1; excp = 1; excp_pc = 32'hDEADBEEF;
        is_load = 1; we = 1; waddr = 4; re1 = 1; raddr1 = 4;
        want = '0;
        #1; n_vec++;
        if (act !== want) begin
            n_err++; $display("FAIL reset_mid_div: got %h want %h", act, want);
        end
        tick();
        clear_inputs();
        rst = 0; req = 1;
        want = {6'b001111, 1'b0, 32'h0, 2'b10};
        #1; n_vec++;
        if (act !== want) begin
            n_err++; $display("FAIL reset_fresh_start: got %h want %h", act, want);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rst     = ($urandom_range(0, 99) < 2);
            excp    = ($urandom_range(0, 99) < 4);
            excp_pc = $urandom;
            if ($urandom_range(0, 99) < 10) req = ~req;
            done    = ($urandom_range(0, 99) < 15);
            dbus    = ($urandom_range(0, 99) < 20);
            ibus    = ($urandom_range(0, 99) < 25);
            is_load = 1'($urandom);
            we      = 1'($urandom);
            waddr   = 5'($urandom_range(0, 3));
            raddr1  = 5'($urandom_range(0, 3));
            raddr2  = 5'($urandom_range(0, 3));
            re1     = 1'($urandom);
            re2     = 1'($urandom);
            want = model_out();
            #1; n_vec++;
            if (act !== want) begin
                n_err++; $display("FAIL random_%0d: got %h want %h", i, act, want);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_divide();
        test_div_dbus();
        test_excp_mid_div();
        test_priority();
        test_reset_mid_div();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
